// File: rtl/trdb_pkg.sv
// trdb_pkg: shared state encoding, message codes and header layout for the trace stream merger
package trdb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PKT,
        SW_DATA,
        TS_LO,
        TS_HI,
        FLUSH_WAIT,
        FLUSH_DONE
    } merger_state_e;

    localparam logic [3:0] MSG_SW    = 4'hA;
    localparam logic [3:0] MSG_TS    = 4'hB;
    localparam logic [3:0] MSG_FLUSH = 4'hF;

    typedef struct packed {
        logic [3:0]  code;
        logic [19:0] rsvd;
        logic [7:0]  seq;
    } trdb_msg_hdr_t;

    function automatic logic [31:0] make_hdr(logic [3:0] code, logic [27:0] payload);
        return {code, payload};
    endfunction

endpackage

// File: rtl/trdb_out_reg.sv
// trdb_out_reg: single-entry valid/ready output register with synchronous clear
module trdb_out_reg (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        ready_i,
    output logic        ld_o,
    output logic [31:0] data_o,
    output logic        valid_o
);

    assign ld_o = !valid_o || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else if (ld_o) begin
            valid_o <= load_i;
            if (load_i) data_o <= data_i;
        end
    end

endmodule

// File: rtl/trdb_stream_merger.sv
// trdb_stream_merger: merges trace packets, timestamps and software words into one 32-bit stream with flush handshake
module trdb_stream_merger #(
    parameter int unsigned SEQ_WIDTH   = 8,
    parameter int unsigned TIMER_WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_fifo_i,
    input  logic [31:0]            packet_word_i,
    input  logic                   packet_valid_i,
    input  logic                   packet_last_i,
    output logic                   packet_grant_o,
    input  logic [31:0]            sw_word_i,
    input  logic                   sw_valid_i,
    output logic                   sw_grant_o,
    input  logic                   tu_req_i,
    input  logic [TIMER_WIDTH-1:0] timer_i,
    output logic                   ts_drop_o,
    input  logic                   flush_stream_i,
    output logic                   flush_confirm_o,
    output logic [31:0]            out_word_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);
    import trdb_pkg::*;

    merger_state_e          state_q, state_d;
    logic [SEQ_WIDTH-1:0]   seq_q;
    logic [TIMER_WIDTH-1:0] ts_q;
    logic                   ts_pending_q, ts_drop_q;
    logic                   ld, load, seq_inc, ts_clr;
    logic [31:0]            word;

    trdb_out_reg u_out_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_fifo_i),
        .load_i  (load),
        .data_i  (word),
        .ready_i (out_ready_i),
        .ld_o    (ld),
        .data_o  (out_word_o),
        .valid_o (out_valid_o)
    );

    assign flush_confirm_o = state_q == FLUSH_DONE;
    assign ts_drop_o       = ts_drop_q;

    always_comb begin
        state_d        = state_q;
        load           = 1'b0;
        word           = '0;
        packet_grant_o = 1'b0;
        sw_grant_o     = 1'b0;
        seq_inc        = 1'b0;
        ts_clr         = 1'b0;
        if (clear_fifo_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (ld) begin
                    if (packet_valid_i) begin
                        load           = 1'b1;
                        word           = packet_word_i;
                        packet_grant_o = 1'b1;
                        state_d        = packet_last_i ? IDLE : PKT;
                    end else if (ts_pending_q) begin
                        load    = 1'b1;
                        word    = make_hdr(MSG_TS, '0);
                        state_d = TS_LO;
                    end else if (sw_valid_i) begin
                        load    = 1'b1;
                        word    = make_hdr(MSG_SW, 28'(seq_q));
                        state_d = SW_DATA;
                    end else if (flush_stream_i) begin
                        load    = 1'b1;
                        word    = make_hdr(MSG_FLUSH, '0);
                        state_d = FLUSH_WAIT;
                    end
                end
                PKT: if (ld && packet_valid_i) begin
                    load           = 1'b1;
                    word           = packet_word_i;
                    packet_grant_o = 1'b1;
                    state_d        = packet_last_i ? IDLE : PKT;
                end
                SW_DATA: if (ld && sw_valid_i) begin
                    load       = 1'b1;
                    word       = sw_word_i;
                    sw_grant_o = 1'b1;
                    seq_inc    = 1'b1;
                    state_d    = IDLE;
                end
                TS_LO: if (ld) begin
                    load    = 1'b1;
                    word    = ts_q[31:0];
                    state_d = TS_HI;
                end
                TS_HI: if (ld) begin
                    load    = 1'b1;
                    word    = 32'(ts_q >> 32);
                    ts_clr  = 1'b1;
                    state_d = IDLE;
                end
                FLUSH_WAIT: state_d = (out_valid_o && out_ready_i) ? FLUSH_DONE : FLUSH_WAIT;
                FLUSH_DONE: state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            ts_q         <= '0;
            ts_pending_q <= 1'b0;
            ts_drop_q    <= 1'b0;
        end else if (clear_fifo_i) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            ts_pending_q <= 1'b0;
            ts_drop_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (seq_inc) seq_q <= seq_q + 1'b1;
            if (tu_req_i && (!ts_pending_q || ts_clr)) begin
                ts_q         <= timer_i;
                ts_pending_q <= 1'b1;
            end else if (ts_clr) begin
                ts_pending_q <= 1'b0;
            end
            ts_drop_q <= tu_req_i && ts_pending_q && !ts_clr;
        end
    end

endmodule

// File: tb/tb_trdb_stream_merger.sv
// tb_trdb_stream_merger: randomized scenario bench with queue-based reference model for the stream merger
module tb_trdb_stream_merger;

    typedef struct {
        logic [31:0] w;
        logic        last;
    } pkt_t;

    logic        clk_i          = 1'b0;
    logic        rst_ni         = 1'b0;
    logic        clear_fifo_i   = 1'b0;
    logic [31:0] packet_word_i  = '0;
    logic        packet_valid_i = 1'b0;
    logic        packet_last_i  = 1'b0;
    logic        packet_grant_o;
    logic [31:0] sw_word_i      = '0;
    logic        sw_valid_i     = 1'b0;
    logic        sw_grant_o;
    logic        tu_req_i       = 1'b0;
    logic [63:0] timer_i        = '0;
    logic        ts_drop_o;
    logic        flush_stream_i = 1'b0;
    logic        flush_confirm_o;
    logic [31:0] out_word_o;
    logic        out_valid_o;
    logic        out_ready_i    = 1'b1;

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;
    int seq_exp = 0;
    pkt_t        pkt_q[$];
    logic [31:0] sw_q[$];
    logic [31:0] got[$];
    int n_cyc = 0, sw_grants = 0, pkt_grants = 0, drops = 0, confirms = 0, stab_err = 0;
    int marker_cyc = -1, conf_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;

    trdb_stream_merger dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_fifo_i    (clear_fifo_i),
        .packet_word_i   (packet_word_i),
        .packet_valid_i  (packet_valid_i),
        .packet_last_i   (packet_last_i),
        .packet_grant_o  (packet_grant_o),
        .sw_word_i       (sw_word_i),
        .sw_valid_i      (sw_valid_i),
        .sw_grant_o      (sw_grant_o),
        .tu_req_i        (tu_req_i),
        .timer_i         (timer_i),
        .ts_drop_o       (ts_drop_o),
        .flush_stream_i  (flush_stream_i),
        .flush_confirm_o (flush_confirm_o),
        .out_word_o      (out_word_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        n_cyc++;
        if (out_valid_o && out_ready_i) begin
            got.push_back(out_word_o);
            if (out_word_o == 32'hF000_0000) marker_cyc = n_cyc;
        end
        if (sw_grant_o) sw_grants++;
        if (packet_grant_o) pkt_grants++;
        if (ts_drop_o) drops++;
        if (flush_confirm_o) begin
            confirms++;
            conf_cyc = n_cyc;
        end
        if (prev_stall && rst_ni && (!out_valid_o || out_word_o !== prev_word)) stab_err++;
        prev_stall = out_valid_o && !out_ready_i && rst_ni && !clear_fifo_i;
        prev_word  = out_word_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sw_hdr(int s);
        return {4'hA, 20'h0, 8'(s)};
    endfunction

    function automatic logic [31:0] word_at(int i);
        if (i < got.size()) return got[i];
        return 32'hxxxx_xxxx;
    endfunction

    // One clock of the upstream sources: retire granted words, present queue heads, set downstream ready.
    task automatic tick();
        logic gp, gs;
        @(negedge clk_i);
        gp = packet_grant_o;
        gs = sw_grant_o;
        @(posedge clk_i);
        #1;
        if (gp && pkt_q.size() > 0) pkt_q.delete(0);
        if (gs && sw_q.size() > 0) sw_q.delete(0);
        if (pkt_q.size() > 0) begin
            packet_valid_i = 1'b1;
            packet_word_i  = pkt_q[0].w;
            packet_last_i  = pkt_q[0].last;
        end else begin
            packet_valid_i = 1'b0;
            packet_last_i  = 1'b0;
        end
        if (sw_q.size() > 0) begin
            sw_valid_i = 1'b1;
            sw_word_i  = sw_q[0];
        end else begin
            sw_valid_i = 1'b0;
        end
        out_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        tests++;
        if ({out_valid_o, out_word_o} !== 33'h0) begin
            fails++;
            $display("FAIL reset_out: valid=%b word=%h, required 0/00000000", out_valid_o, out_word_o);
        end
        tests++;
        if ({packet_grant_o, sw_grant_o, ts_drop_o, flush_confirm_o} !== 4'h0) begin
            fails++;
            $display("FAIL reset_flags: pg/sg/drop/conf=%b, required 0000",
                     {packet_grant_o, sw_grant_o, ts_drop_o, flush_confirm_o});
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        tests++;
        if (out_valid_o !== 1'b0 || got.size() != 0) begin
            fails++;
            $display("FAIL idle_after_reset: valid=%b words=%0d, required 0/0", out_valid_o, got.size());
        end
    endtask

    task automatic test_trace_priority();
        logic [31:0] a[3];
        logic [31:0] exp[$];
        int gi, sg;
        gi = got.size();
        sg = sw_grants;
        ready_mode = 0;
        for (int k = 0; k < 3; k++) begin
            a[k] = $urandom;
            pkt_q.push_back('{w: a[k], last: 1'(k == 2)});
            exp.push_back(a[k]);
        end
        sw_q.push_back(32'h0000_1234);
        exp.push_back(sw_hdr(seq_exp));
        exp.push_back(32'h0000_1234);
        for (int i = 0; i < 100 && got.size() < gi + 5; i++) tick();
        repeat (5) tick();
        tests++;
        if (got.size() != gi + 5) begin
            fails++;
            $display("FAIL trace_count: got %0d words, required 5", got.size() - gi);
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (word_at(gi + k) !== exp[k]) begin
                fails++;
                $display("FAIL trace_word[%0d]: got %h, required %h", k, word_at(gi + k), exp[k]);
            end
        end
        tests++;
        if (sw_grants - sg != 1) begin
            fails++;
            $display("FAIL trace_sw_grants: got %0d, required 1", sw_grants - sg);
        end
        seq_exp = (seq_exp + 1) % 256;
    endtask

    task automatic test_timestamp();
        logic [31:0] exp[3];
        int gi, dr;
        exp = '{32'hB000_0000, 32'hDEAD_BEEF, 32'h0000_0005};
        gi = got.size();
        dr = drops;
        ready_mode = 2;
        tu_req_i = 1'b1;
        timer_i  = 64'h0000_0005_DEAD_BEEF;
        tick();
        tu_req_i = 1'b0;
        tick();
        tick();
        tu_req_i = 1'b1;
        timer_i  = {$urandom, $urandom};
        tick();
        tu_req_i = 1'b0;
        tests++;
        if (ts_drop_o !== 1'b1) begin
            fails++;
            $display("FAIL ts_drop_pulse: got %b, required 1", ts_drop_o);
        end
        tick();
        tests++;
        if (ts_drop_o !== 1'b0) begin
            fails++;
            $display("FAIL ts_drop_width: got %b, required 0", ts_drop_o);
        end
        ready_mode = 0;
        for (int i = 0; i < 100 && got.size() < gi + 3; i++) tick();
        repeat (10) tick();
        tests++;
        if (got.size() != gi + 3) begin
            fails++;
            $display("FAIL ts_count: got %0d words, required 3", got.size() - gi);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (word_at(gi + k) !== exp[k]) begin
                fails++;
                $display("FAIL ts_word[%0d]: got %h, required %h", k, word_at(gi + k), exp[k]);
            end
        end
        tests++;
        if (drops - dr != 1) begin
            fails++;
            $display("FAIL ts_drop_count: got %0d, required 1", drops - dr);
        end
    endtask

    task automatic test_ts_simultaneous();
        logic [63:0] t1, t2;
        logic [31:0] exp[6];
        int gi, dr;
        t1 = {$urandom, $urandom};
        t2 = {$urandom, $urandom};
        exp = '{32'hB000_0000, t1[31:0], t1[63:32], 32'hB000_0000, t2[31:0], t2[63:32]};
        gi = got.size();
        dr = drops;
        ready_mode = 0;
        tu_req_i = 1'b1;
        timer_i  = t1;
        tick();
        tu_req_i = 1'b0;
        tick();
        tick();
        tu_req_i = 1'b1;
        timer_i  = t2;
        tick();
        tu_req_i = 1'b0;
        for (int i = 0; i < 100 && got.size() < gi + 6; i++) tick();
        repeat (10) tick();
        tests++;
        if (got.size() != gi + 6) begin
            fails++;
            $display("FAIL ts_sim_count: got %0d words, required 6", got.size() - gi);
        end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (word_at(gi + k) !== exp[k]) begin
                fails++;
                $display("FAIL ts_sim_word[%0d]: got %h, required %h", k, word_at(gi + k), exp[k]);
            end
        end
        tests++;
        if (drops - dr != 0) begin
            fails++;
            $display("FAIL ts_sim_drops: got %0d, required 0", drops - dr);
        end
    endtask

    task automatic test_sw_backpressure();
        logic [31:0] exp[$];
        int gi, sg, se, n_err;
        clear_fifo_i = 1'b1;
        tick();
        clear_fifo_i = 1'b0;
        seq_exp = 0;
        gi = got.size();
        sg = sw_grants;
        se = stab_err;
        ready_mode = 1;
        for (int i = 0; i < 257; i++) begin
            logic [31:0] w;
            w = $urandom;
            sw_q.push_back(w);
            exp.push_back(sw_hdr(seq_exp));
            exp.push_back(w);
            seq_exp = (seq_exp + 1) % 256;
        end
        for (int i = 0; i < 5000 && got.size() < gi + 514; i++) tick();
        ready_mode = 0;
        repeat (5) tick();
        tests++;
        if (got.size() != gi + 514) begin
            fails++;
            $display("FAIL sw_count: got %0d words, required 514", got.size() - gi);
        end
        n_err = 0;
        for (int k = 0; k < 514; k++) begin
            tests++;
            if (word_at(gi + k) !== exp[k]) begin
                fails++;
                if (n_err++ < 8) $display("FAIL sw_word[%0d]: got %h, required %h", k, word_at(gi + k), exp[k]);
            end
        end
        tests++;
        if (sw_grants - sg != 257) begin
            fails++;
            $display("FAIL sw_grants: got %0d, required 257", sw_grants - sg);
        end
        tests++;
        if (stab_err - se != 0) begin
            fails++;
            $display("FAIL sw_stable: %0d words changed under backpressure, required 0", stab_err - se);
        end
    endtask

    task automatic test_flush();
        logic [31:0] w;
        logic [31:0] exp[3];
        logic seen;
        int gi, cf;
        w = $urandom;
        exp = '{sw_hdr(seq_exp), w, 32'hF000_0000};
        gi = got.size();
        cf = confirms;
        ready_mode = 0;
        sw_q.push_back(w);
        tick();
        flush_stream_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = flush_confirm_o;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL flush_timeout: confirm=%b, required 1 within 40 cycles", seen);
        end
        tick();
        flush_stream_i = 1'b0;
        repeat (10) tick();
        tests++;
        if (got.size() != gi + 3) begin
            fails++;
            $display("FAIL flush_count: got %0d words, required 3", got.size() - gi);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (word_at(gi + k) !== exp[k]) begin
                fails++;
                $display("FAIL flush_word[%0d]: got %h, required %h", k, word_at(gi + k), exp[k]);
            end
        end
        tests++;
        if (confirms - cf != 1) begin
            fails++;
            $display("FAIL flush_confirms: got %0d pulses, required 1", confirms - cf);
        end
        tests++;
        if (conf_cyc != marker_cyc + 1) begin
            fails++;
            $display("FAIL flush_timing: confirm cycle %0d, required %0d", conf_cyc, marker_cyc + 1);
        end
        seq_exp = (seq_exp + 1) % 256;
    endtask

    task automatic test_clear_mid_packet();
        logic [31:0] a1, b1, b2, w;
        logic [31:0] exp[5];
        int gi, pg;
        a1 = $urandom;
        b1 = $urandom;
        b2 = $urandom;
        w  = $urandom;
        gi = got.size();
        pg = pkt_grants;
        ready_mode = 0;
        pkt_q.push_back('{w: a1, last: 1'b0});
        pkt_q.push_back('{w: $urandom, last: 1'b0});
        pkt_q.push_back('{w: $urandom, last: 1'b1});
        for (int i = 0; i < 20 && pkt_grants - pg < 1; i++) tick();
        clear_fifo_i = 1'b1;
        pkt_q.delete();
        tick();
        clear_fifo_i = 1'b0;
        seq_exp = 0;
        tests++;
        if (out_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL clear_valid: got %b, required 0", out_valid_o);
        end
        sw_q.push_back(w);
        for (int i = 0; i < 50 && got.size() < gi + 3; i++) tick();
        pkt_q.push_back('{w: b1, last: 1'b0});
        pkt_q.push_back('{w: b2, last: 1'b1});
        for (int i = 0; i < 50 && got.size() < gi + 5; i++) tick();
        repeat (5) tick();
        exp = '{a1, sw_hdr(seq_exp), w, b1, b2};
        tests++;
        if (got.size() != gi + 5) begin
            fails++;
            $display("FAIL clear_count: got %0d words, required 5", got.size() - gi);
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (word_at(gi + k) !== exp[k]) begin
                fails++;
                $display("FAIL clear_word[%0d]: got %h, required %h", k, word_at(gi + k), exp[k]);
            end
        end
        tests++;
        if (pkt_grants - pg != 3) begin
            fails++;
            $display("FAIL clear_pkt_grants: got %0d, required 3", pkt_grants - pg);
        end
        seq_exp = (seq_exp + 1) % 256;
    endtask

    task automatic test_reset_mid_ts();
        int gi;
        gi = got.size();
        ready_mode = 2;
        tu_req_i = 1'b1;
        timer_i  = {$urandom, $urandom};
        tick();
        tu_req_i = 1'b0;
        tick();
        tick();
        tests++;
        if (out_valid_o !== 1'b1 || out_word_o !== 32'hB000_0000) begin
            fails++;
            $display("FAIL rst_pre_state: valid=%b word=%h, required 1/b0000000", out_valid_o, out_word_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({out_valid_o, out_word_o} !== 33'h0) begin
            fails++;
            $display("FAIL rst_async_out: valid=%b word=%h, required 0/00000000", out_valid_o, out_word_o);
        end
        tests++;
        if ({packet_grant_o, sw_grant_o, ts_drop_o, flush_confirm_o} !== 4'h0) begin
            fails++;
            $display("FAIL rst_async_flags: pg/sg/drop/conf=%b, required 0000",
                     {packet_grant_o, sw_grant_o, ts_drop_o, flush_confirm_o});
        end
        tick();
        tick();
        rst_ni = 1'b1;
        ready_mode = 0;
        repeat (10) tick();
        tests++;
        if (got.size() != gi || out_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_ts: got %0d words valid=%b, required 0 words valid=0", got.size() - gi, out_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_trace_priority();
        test_timestamp();
        test_ts_simultaneous();
        test_sw_backpressure();
        test_flush();
        test_clear_mid_packet();
        test_reset_mid_ts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
